// File: rtl/dual_digit_counter.sv
// Two-digit up/down counter fed by three debounced pushbuttons, driving a dual seven-segment stage.
// Build option: define DUALSEG_BCD_EN for a 00..99 BCD counter; otherwise the counter is 8-bit hex.

module DualDigitDebounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

  state_t r_state;
  state_t w_nextState;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_nextCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // The press pulse is emitted on the ARM->HELD transition itself, so the
  // counter can act on the very next edge.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    o_pulse     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_level) begin
          w_nextState = ARM;
          w_nextCount = '0;
        end
      end
      ARM: begin
        if (!i_level) begin
          w_nextState = IDLE;
        end else if (r_count == LAST) begin
          w_nextState = HELD;
          o_pulse     = 1'b1;
        end else begin
          w_nextCount = r_count + 1'b1;
        end
      end
      HELD: begin
        if (!i_level) begin
          w_nextState = REL;
          w_nextCount = '0;
        end
      end
      REL: begin
        if (i_level) begin
          w_nextState = HELD;
        end else if (r_count == LAST) begin
          w_nextState = IDLE;
        end else begin
          w_nextCount = r_count + 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCount = '0;
      end
    endcase
  end

endmodule

module dual_digit_counter #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_clr,
  input  logic       test_sw,
  output logic [7:0] push_out,
  output logic       blank,
  output logic       test,
  output logic       wrap
);

  localparam int TW = $clog2(BLINK_CYCLES + 1);
  localparam logic [TW-1:0] BLINK_LOAD = TW'(BLINK_CYCLES - 1);

  // Bit order: {test_sw, key_clr, key_dec, key_inc}
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  logic w_incPulse;
  logic w_decPulse;
  logic w_clrPulse;

  logic [7:0]    r_digits;
  logic          r_blank;
  logic          r_wrap;
  logic [TW-1:0] r_timer;

  logic [7:0] w_upVal;
  logic [7:0] w_downVal;
  logic       w_upWrap;
  logic       w_downWrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {test_sw, key_clr, key_dec, key_inc};
      r_sync2 <= r_sync1;
    end
  end

  DualDigitDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debInc (
    .clk(clk), .reset(reset), .i_level(r_sync2[0]), .o_pulse(w_incPulse)
  );
  DualDigitDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debDec (
    .clk(clk), .reset(reset), .i_level(r_sync2[1]), .o_pulse(w_decPulse)
  );
  DualDigitDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debClr (
    .clk(clk), .reset(reset), .i_level(r_sync2[2]), .o_pulse(w_clrPulse)
  );

  always_comb begin
    w_upVal    = r_digits;
    w_downVal  = r_digits;
    w_upWrap   = 1'b0;
    w_downWrap = 1'b0;
`ifdef DUALSEG_BCD_EN
    if (r_digits[3:0] == 4'd9) begin
      w_upVal[3:0] = 4'd0;
      if (r_digits[7:4] == 4'd9) begin
        w_upVal[7:4] = 4'd0;
        w_upWrap     = 1'b1;
      end else begin
        w_upVal[7:4] = r_digits[7:4] + 4'd1;
      end
    end else begin
      w_upVal[3:0] = r_digits[3:0] + 4'd1;
    end
    if (r_digits[3:0] == 4'd0) begin
      w_downVal[3:0] = 4'd9;
      if (r_digits[7:4] == 4'd0) begin
        w_downVal[7:4] = 4'd9;
        w_downWrap     = 1'b1;
      end else begin
        w_downVal[7:4] = r_digits[7:4] - 4'd1;
      end
    end else begin
      w_downVal[3:0] = r_digits[3:0] - 4'd1;
    end
`else
    w_upVal    = r_digits + 8'd1;
    w_downVal  = r_digits - 8'd1;
    w_upWrap   = (r_digits == 8'hFF);
    w_downWrap = (r_digits == 8'h00);
`endif
  end

  // Clear outranks inc/dec; simultaneous inc and dec cancel; lamp test freezes
  // the value while the blink timer keeps running down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits <= 8'h00;
      r_blank  <= 1'b0;
      r_wrap   <= 1'b0;
      r_timer  <= '0;
    end else begin
      r_wrap <= 1'b0;
      if (r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end else begin
        r_blank <= 1'b0;
      end
      if (!r_sync2[3]) begin
        if (w_clrPulse) begin
          r_digits <= 8'h00;
          r_blank  <= 1'b0;
          r_timer  <= '0;
        end else if (w_incPulse && !w_decPulse) begin
          r_digits <= w_upVal;
          if (w_upWrap) begin
            r_wrap  <= 1'b1;
            r_blank <= 1'b1;
            r_timer <= BLINK_LOAD;
          end
        end else if (w_decPulse && !w_incPulse) begin
          r_digits <= w_downVal;
          if (w_downWrap) begin
            r_wrap  <= 1'b1;
            r_blank <= 1'b1;
            r_timer <= BLINK_LOAD;
          end
        end
      end
    end
  end

  assign push_out = r_digits;
  assign blank    = r_blank;
  assign test     = r_sync2[3];
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_dual_digit_counter.sv
// Scoreboard bench for dual_digit_counter (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8).
// Every expected output change is queued with its cycle; a monitor pops one per observed change.

module tb_dual_digit_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_inc;
  logic       key_dec;
  logic       key_clr;
  logic       test_sw;
  logic [7:0] push_out;
  logic       blank;
  logic       test;
  logic       wrap;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic monEn = 1'b0;
  logic [7:0] model;

`ifdef DUALSEG_BCD_EN
  localparam logic [7:0] MAXV = 8'h99;
`else
  localparam logic [7:0] MAXV = 8'hFF;
`endif

  localparam logic [2:0] K_INC = 3'b001;
  localparam logic [2:0] K_DEC = 3'b010;
  localparam logic [2:0] K_CLR = 3'b100;

  typedef struct {
    int         cyc;
    logic [10:0] val;
  } exp_t;

  exp_t expQ[$];

  dual_digit_counter #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .key_inc(key_inc), .key_dec(key_dec),
    .key_clr(key_clr), .test_sw(test_sw), .push_out(push_out),
    .blank(blank), .test(test), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushExp(input int c, input logic [7:0] v, input logic b,
                         input logic t, input logic w);
    exp_t e;
    e.cyc = c;
    e.val = {v, b, t, w};
    expQ.push_back(e);
  endtask

  function automatic logic [7:0] incModel(input logic [7:0] v);
`ifdef DUALSEG_BCD_EN
    int d;
    d = int'(v[7:4]) * 10 + int'(v[3:0]);
    d = (d + 1) % 100;
    return {4'(d / 10), 4'(d % 10)};
`else
    return v + 8'd1;
`endif
  endfunction

  task automatic checkOutput(input logic [10:0] cur);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_change: got {push,blank,test,wrap}=%h_%b%b%b at cycle %0d, none expected",
               cur[10:3], cur[2], cur[1], cur[0], cyc);
    end else begin
      e = expQ.pop_front();
      if (e.val !== cur || e.cyc != cyc) begin
        errors++;
        $display("[TB] FAIL output_change: got %h_%b%b%b at cycle %0d, need %h_%b%b%b at cycle %0d",
                 cur[10:3], cur[2], cur[1], cur[0], cyc,
                 e.val[10:3], e.val[2], e.val[1], e.val[0], e.cyc);
      end
    end
  endtask

  // Monitor: any change in the observable output vector is one DUT event.
  logic [10:0] prevOut;
  always @(negedge clk) begin
    logic [10:0] cur;
    cur = {push_out, blank, test, wrap};
    if (monEn && cur !== prevOut) checkOutput(cur);
    prevOut = cur;
  end

  // Press the given keys at a falling edge, hold, release, and let debounce settle.
  task automatic applyStimulus(input logic [2:0] keys, input int hold,
                               input logic [7:0] expVal, input logic expWrap);
    int n;
    n = cyc;
    if (expWrap) begin
      pushExp(n + 7, expVal, 1'b1, 1'b0, 1'b1);
      pushExp(n + 8, expVal, 1'b1, 1'b0, 1'b0);
      pushExp(n + 15, expVal, 1'b0, 1'b0, 1'b0);
    end else if (expVal != model) begin
      pushExp(n + 7, expVal, 1'b0, 1'b0, 1'b0);
    end
    model = expVal;
    {key_clr, key_dec, key_inc} = keys;
    repeat (hold) @(negedge clk);
    {key_clr, key_dec, key_inc} = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  task automatic checkReset(input string name, input logic [7:0] act);
    checks++;
    if (act !== 8'h00) begin
      errors++;
      $display("[TB] FAIL %s: got %h, need 00", name, act);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    logic didBorrow;
    didBorrow = 1'b0;
    reset = 1'b1;
    {key_clr, key_dec, key_inc} = 3'b000;
    test_sw = 1'b0;
    model = 8'h00;
    repeat (3) @(negedge clk);
    checkReset("reset_push_out", push_out);
    checkReset("reset_blank", {7'd0, blank});
    checkReset("reset_test", {7'd0, test});
    checkReset("reset_wrap", {7'd0, wrap});
    reset = 1'b0;
    monEn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] long hold gives a single step");
    applyStimulus(K_INC, 20, 8'h01, 1'b0);

    $display("[TB] bounce shorter than debounce window is ignored");
    for (int i = 0; i < 3; i++) begin
      key_inc = 1'b1;
      repeat (2) @(negedge clk);
      key_inc = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    applyStimulus(K_INC, 8, 8'h02, 1'b0);

    $display("[TB] wrap in both directions with blink");
    applyStimulus(K_CLR, 8, 8'h00, 1'b0);
    applyStimulus(K_DEC, 8, MAXV, 1'b1);
    applyStimulus(K_INC, 8, 8'h00, 1'b1);
    applyStimulus(K_DEC, 8, MAXV, 1'b1);

    $display("[TB] count up to 42");
    applyStimulus(K_CLR, 8, 8'h00, 1'b0);
    while (model != 8'h42) begin
      applyStimulus(K_INC, 8, incModel(model), 1'b0);
`ifdef DUALSEG_BCD_EN
      if (model == 8'h10 && !didBorrow) begin
        applyStimulus(K_DEC, 8, 8'h09, 1'b0);
        applyStimulus(K_INC, 8, 8'h10, 1'b0);
        didBorrow = 1'b1;
      end
`endif
    end

    $display("[TB] simultaneous key combinations");
    applyStimulus(K_INC | K_CLR, 8, 8'h00, 1'b0);
    applyStimulus(K_INC, 8, 8'h01, 1'b0);
    applyStimulus(K_INC | K_DEC, 8, 8'h01, 1'b0);

    $display("[TB] lamp test freezes the counter");
    n = cyc;
    pushExp(n + 2, model, 1'b0, 1'b1, 1'b0);
    test_sw = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(K_INC, 8, model, 1'b0);
    applyStimulus(K_CLR, 8, model, 1'b0);
    n = cyc;
    pushExp(n + 2, model, 1'b0, 1'b0, 1'b0);
    test_sw = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] reset during blink");
    applyStimulus(K_CLR, 8, 8'h00, 1'b0);
    n = cyc;
    pushExp(n + 7, MAXV, 1'b1, 1'b0, 1'b1);
    pushExp(n + 8, MAXV, 1'b1, 1'b0, 1'b0);
    key_dec = 1'b1;
    repeat (10) @(negedge clk);
    n = cyc;
    pushExp(n + 1, 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    key_dec = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    model = 8'h00;
    repeat (20) @(negedge clk);

    while (expQ.size() != 0) begin
      exp_t e;
      e = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_change: got nothing, need %h_%b%b%b at cycle %0d",
               e.val[10:3], e.val[2], e.val[1], e.val[0], e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
